// File: rtl/muon_lifetime_pkg.sv
// muon_lifetime_pkg: shared BCD types, display mode encoding and 7-segment constants
package muon_lifetime_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef logic [15:0] bcd_word_t;
  typedef enum logic [1:0] {
    MODE_AB    = 2'b00,
    MODE_COINC = 2'b01,
    MODE_TDC   = 2'b10,
    MODE_OFF   = 2'b11
  } mode_t;
  typedef enum logic {TDC_IDLE, TDC_RUN} tdc_state_t;
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam bcd_word_t TDC_SENTINEL = 16'h9999;
  function automatic logic [6:0] seg_of(input bcd_digit_t d);
    return d > 4'd9 ? SEG_BLANK : SEG_LUT[d];
  endfunction
  function automatic bcd_word_t to_bcd(input int v);
    bcd_word_t r;
    int n;
    n = v;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_counter4.sv
// bcd_counter4: 4-digit BCD counter with synchronous clear, increment enable and 9999->0000 wrap
module bcd_counter4
  import muon_lifetime_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      inc,
  output bcd_word_t q
);
  logic [3:0] carry;
  bcd_word_t nxt;
  assign carry[0] = 1'b1;
  for (genvar d = 0; d < 4; d++) begin : g_dig
    assign nxt[d*4 +: 4] = !carry[d] ? q[d*4 +: 4] : q[d*4 +: 4] == 4'd9 ? 4'd0 : q[d*4 +: 4] + 4'd1;
    if (d < 3) begin : g_carry
      assign carry[d+1] = carry[d] && q[d*4 +: 4] == 4'd9;
    end
  end
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (inc) q <= nxt;
endmodule

// File: rtl/muon_lifetime_top.sv
// muon_lifetime_top: A/B/AB pulse counters, AB->C interval TDC and 8-digit 7-segment display; define TDC_EN to build the TDC
module muon_lifetime_top
  import muon_lifetime_pkg::*;
#(
  parameter int REFRESH_DIV = 1024,
  parameter int TDC_TIMEOUT = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] buttons,
  input  logic       sw_left,
  input  logic       sw_right,
  output logic [6:0] segments,
  output logic [7:0] anodes
);
  localparam int DIV_W = $clog2(REFRESH_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  logic [2:0] s1, s2, s3;
  logic [1:0] m1;
  mode_t mode;
  logic p_a, p_b, p_c, p_ab;
  bcd_word_t count_a, count_b, count_ab, lo;
  logic [DIV_W-1:0] div;
  logic [2:0] idx;
  logic lo_on, on;
  bcd_digit_t digit;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      m1 <= '0;
      mode <= MODE_AB;
    end else begin
      s1 <= buttons;
      s2 <= s1;
      s3 <= s2;
      m1 <= {sw_left, sw_right};
      mode <= mode_t'(m1);
    end
  assign p_a = s2[0] & ~s3[0];
  assign p_b = s2[1] & ~s3[1];
  assign p_c = s2[2] & ~s3[2];
  assign p_ab = &s2[1:0] & ~&s3[1:0];
  bcd_counter4 u_cnt_a (.clk(clk), .rst(rst), .clr(1'b0), .inc(p_a), .q(count_a));
  bcd_counter4 u_cnt_b (.clk(clk), .rst(rst), .clr(1'b0), .inc(p_b), .q(count_b));
  bcd_counter4 u_cnt_ab (.clk(clk), .rst(rst), .clr(1'b0), .inc(p_ab), .q(count_ab));
`ifdef TDC_EN
  localparam bcd_word_t TIMEOUT_BCD = to_bcd(TDC_TIMEOUT);
  tdc_state_t state, state_nxt;
  bcd_word_t run_cnt, tdc_value, tdc_nxt;
  logic stop;
  bcd_counter4 u_run (.clk(clk), .rst(rst), .clr(state_nxt == TDC_IDLE), .inc(1'b1), .q(run_cnt));
  always_comb begin
    stop = state == TDC_RUN && (p_c || run_cnt == TIMEOUT_BCD);
    state_nxt = state == TDC_IDLE ? (p_ab ? TDC_RUN : TDC_IDLE) : stop ? TDC_IDLE : TDC_RUN;
    tdc_nxt = !stop ? tdc_value : p_c ? run_cnt : TDC_SENTINEL;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= TDC_IDLE;
      tdc_value <= '0;
    end else begin
      state <= state_nxt;
      tdc_value <= tdc_nxt;
    end
  assign lo = mode == MODE_AB ? count_b : mode == MODE_COINC ? count_ab : tdc_value;
  assign lo_on = mode != MODE_OFF;
`else
  logic unused_c;
  assign unused_c = p_c;
  assign lo = mode == MODE_AB ? count_b : count_ab;
  assign lo_on = mode == MODE_AB || mode == MODE_COINC;
`endif
  assign on = idx[2] ? mode == MODE_AB : lo_on;
  assign digit = idx[2] ? count_a[{idx[1:0], 2'b00} +: 4] : lo[{idx[1:0], 2'b00} +: 4];
  always_ff @(posedge clk)
    if (rst) begin
      div <= '0;
      idx <= '0;
      anodes <= AN_OFF;
      segments <= SEG_BLANK;
    end else begin
      div <= div == DIV_LAST ? '0 : div + 1'b1;
      idx <= div == DIV_LAST ? idx - 3'd1 : idx;
      anodes <= on ? ~(8'd1 << idx) : AN_OFF;
      segments <= on ? seg_of(digit) : SEG_BLANK;
    end
endmodule

// File: tb/tb_muon_lifetime_top.sv
// tb_muon_lifetime_top: randomized and directed checks of counters, TDC and display scan against an event-level model
module tb_muon_lifetime_top;
  localparam int RD = 8;
  localparam int TO = 128;
`ifdef TDC_EN
  localparam bit TDC = 1'b1;
`else
  localparam bit TDC = 1'b0;
`endif
  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int P10 [4] = '{1, 10, 100, 1000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] buttons = '0;
  logic sw_left = 1'b0;
  logic sw_right = 1'b0;
  logic [6:0] segments;
  logic [7:0] anodes;
  int errors = 0;
  int checks = 0;
  muon_lifetime_top #(.REFRESH_DIV(RD), .TDC_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .sw_left(sw_left), .sw_right(sw_right),
    .segments(segments), .anodes(anodes)
  );
  always #5 clk = ~clk;
  bit live = 1'b0;
  bit in_rst = 1'b1;
  int k, ma, mb, mab, mt, j0;
  bit running;
  logic [2:0] b_prev, rise;
  logic ab_r;
  int ha [8], hb [8], hab [8], ht [8];
  logic [1:0] hsw [8];
  always @(posedge clk) begin
    live = 1'b1;
    if (rst) begin
      in_rst = 1'b1;
      k = 0;
      b_prev = '0;
      ma = 0;
      mb = 0;
      mab = 0;
      mt = 0;
      running = 1'b0;
      j0 = 0;
    end else begin
      in_rst = 1'b0;
      k++;
      rise = buttons & ~b_prev;
      ab_r = buttons[0] & buttons[1] & ~(b_prev[0] & b_prev[1]);
      ma = (ma + int'(rise[0])) % 10000;
      mb = (mb + int'(rise[1])) % 10000;
      mab = (mab + int'(ab_r)) % 10000;
      if (running) begin
        if (rise[2]) begin
          mt = k - j0;
          running = 1'b0;
        end else if (k - j0 == TO) begin
          mt = 9999;
          running = 1'b0;
        end
      end else if (ab_r) begin
        running = 1'b1;
        j0 = k;
      end
      b_prev = buttons;
      ha[k%8] = ma;
      hb[k%8] = mb;
      hab[k%8] = mab;
      ht[k%8] = mt;
      hsw[k%8] = {sw_left, sw_right};
    end
  end
  int j, md, d, v, dg;
  logic [7:0] ea;
  logic [6:0] es;
  always @(negedge clk) if (live) begin
    if (in_rst) begin
      ea = 8'hFF;
      es = 7'h7F;
    end else begin
      j = k - 3;
      md = k < 3 ? 0 : int'(hsw[(k-2)%8]);
      d = (8 - ((k - 1) / RD) % 8) % 8;
      if (d >= 4) v = md == 0 ? (j < 1 ? 0 : ha[j%8]) : -1;
      else if (md == 0) v = j < 1 ? 0 : hb[j%8];
      else if (md == 1) v = j < 1 ? 0 : hab[j%8];
      else if (md == 2 && TDC) v = j < 1 ? 0 : ht[j%8];
      else v = -1;
      dg = v < 0 ? -1 : (v / P10[d%4]) % 10;
      ea = dg < 0 ? 8'hFF : ~(8'd1 << d);
      es = dg < 0 ? 7'h7F : SEG[dg];
    end
    checks++;
    if (anodes !== ea || segments !== es) begin
      errors++;
      $display("FAIL scan k=%0d: anodes got %h want %h, segments got %h want %h", k, anodes, ea, segments, es);
    end
  end
  function automatic logic [3:0] dec(input logic [6:0] s);
    logic [3:0] r;
    r = 4'hE;
    for (int i = 0; i < 10; i++) if (SEG[i] == s) r = 4'(i);
    return r;
  endfunction
  function automatic logic [15:0] bcd(input int x);
    logic [15:0] r;
    int n;
    n = x;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction
  task automatic show(input logic [1:0] m, input logic [31:0] want, input string name);
    logic [31:0] cap;
    cap = '1;
    {sw_left, sw_right} = m;
    repeat (8) @(negedge clk);
    repeat (8 * RD) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) if (anodes == ~(8'd1 << i)) cap[i*4 +: 4] = dec(segments);
    end
    checks++;
    if (cap !== want) begin
      errors++;
      $display("FAIL %s: display got %h want %h", name, cap, want);
    end
  endtask
  task automatic press(input logic [2:0] m, input int hold);
    buttons = m;
    repeat (hold) @(negedge clk);
    buttons = '0;
    repeat (hold) @(negedge clk);
  endtask
  task automatic pin(input int got, input int want, input string name);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: model got %0d want %0d", name, got, want);
    end
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    show(2'b00, 32'h0000_0000, "reset zeros");
    repeat (3) press(3'b001, 15);
    repeat (2) press(3'b010, 15);
    press(3'b011, 15);
    show(2'b00, 32'h0004_0003, "counts A B");
    show(2'b01, 32'hFFFF_0001, "count AB");
    pin(ma, 4, "model A");
    pin(mb, 3, "model B");
    pin(mab, 1, "model AB");
`ifdef TDC_EN
    repeat (TO + 10) @(negedge clk);
    buttons = 3'b011;
    repeat (15) @(negedge clk);
    buttons = '0;
    repeat (35) @(negedge clk);
    buttons = 3'b100;
    repeat (15) @(negedge clk);
    buttons = '0;
    show(2'b10, 32'hFFFF_0050, "tdc 50");
    pin(mt, 50, "model tdc 50");
    press(3'b011, 15);
    repeat (TO + 20) @(negedge clk);
    show(2'b10, 32'hFFFF_9999, "tdc timeout");
    pin(mt, 9999, "model timeout");
    press(3'b100, 15);
    show(2'b10, 32'hFFFF_9999, "tdc hold");
    buttons = 3'b011;
    repeat (15) @(negedge clk);
    buttons = '0;
    repeat (45) @(negedge clk);
    buttons = 3'b011;
    repeat (15) @(negedge clk);
    buttons = '0;
    repeat (50) @(negedge clk);
    buttons = 3'b100;
    repeat (15) @(negedge clk);
    buttons = '0;
    show(2'b10, 32'hFFFF_0125, "tdc 125");
    pin(mt, 125, "model tdc 125");
`else
    show(2'b10, 32'hFFFF_FFFF, "tdc mode blank");
`endif
    n = (9999 - ma + 10000) % 10000;
    repeat (n) press(3'b001, 1);
    show(2'b00, {16'h9999, bcd(mb)}, "count 9999");
    press(3'b001, 1);
    show(2'b00, {16'h0000, bcd(mb)}, "count wrap");
    pin(ma, 0, "model wrap");
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) {sw_left, sw_right} = 2'($urandom);
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 15) == 0) buttons[b] = ~buttons[b];
      @(negedge clk);
    end
    buttons = '0;
    show(2'b11, 32'hFFFF_FFFF, "mode 11 blank");
    repeat (TO + 10) @(negedge clk);
    {sw_left, sw_right} = 2'b10;
    buttons = 3'b011;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    buttons = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
`ifdef TDC_EN
    show(2'b10, 32'hFFFF_0000, "reset aborts tdc");
`endif
    show(2'b00, 32'h0000_0000, "reset clears counts");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
